// File: rtl/system_test.sv
// system_test: 16-bit multicycle load/store CPU with a debug/test port that is live while test=0.
// Define SYSTEMTEST_DEBUG_PORTS_EN to drive the FSM debug outputs; otherwise they are tied to 0.
module system_test (
    input  logic        clk,
    input  logic        reset,
    input  logic        test,
    input  logic [15:0] resetpc,
    input  logic        memoryoperation,
    input  logic        memorywrite,
    input  logic [15:0] memaddress,
    input  logic [15:0] memwritedata,
    input  logic        registeroperation,
    input  logic        registerwrite,
    input  logic [3:0]  registeraddress,
    input  logic [15:0] regwritedata,
    output logic [15:0] RD,
    output logic [15:0] MD,
    output logic [15:0] PC,
    output logic [15:0] SP,
    output logic [9:1]  state,
    output logic        FU,
    output logic        RW,
    output logic        PCW,
    output logic        SPW,
    output logic        MW,
    output logic        IW,
    output logic        MSrc,
    output logic        LM,
    output logic        SrcB,
    output logic        Jump,
    output logic        SPIorD,
    output logic        IorD,
    output logic        Perform,
    output logic        LMC,
    output logic        z,
    output logic [2:0]  ALUOp,
    output logic [2:0]  RWSrc,
    output logic [3:0]  Op,
    output logic [15:0] x,
    output logic [3:0]  y,
    output logic [15:0] display
);
    typedef enum logic [8:0] {
        S_FETCH  = 9'b000000001,
        S_DECODE = 9'b000000010,
        S_IMM    = 9'b000000100,
        S_EXEC   = 9'b000001000,
        S_WB     = 9'b000010000,
        S_MEMRD  = 9'b000100000,
        S_MEMWR  = 9'b001000000,
        S_BRANCH = 9'b010000000,
        S_PUSH   = 9'b100000000
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q, sp_q, ir_q, a_q, b_q, md_q, rd_q;
    logic [15:0] mem [1024];
    logic [15:0] regs [16];

    logic [3:0]  op, rd_idx, rs_idx;
    logic [15:0] rd_val, alu_res, sp_dec;
    logic        taken;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we, md_load;
    logic [3:0]  reg_widx;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        unused_addr_bits;

    assign op     = ir_q[15:12];
    assign rd_idx = ir_q[11:8];
    assign rs_idx = ir_q[7:4];
    assign rd_val = regs[rd_idx];
    assign sp_dec = sp_q - 16'd1;
    assign taken  = (op == 4'hF) || ((op == 4'hD) && (rd_val == a_q)) || ((op == 4'hE) && (rd_val != a_q));
    assign unused_addr_bits = ^mem_addr[15:10];

    always_comb begin
        alu_res = 16'h0000;
        case (op[2:0])
            3'd0: alu_res = a_q + b_q;
            3'd1: alu_res = a_q - b_q;
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = {15'd0, $signed(a_q) < $signed(b_q)};
            3'd6: alu_res = a_q << b_q[3:0];
            default: alu_res = a_q >> b_q[3:0];
        endcase
    end

    // One memory port: debug owns it while frozen, otherwise the FSM state picks the address.
    always_comb begin
        mem_addr  = pc_q;
        mem_wdata = rd_val;
        mem_we    = 1'b0;
        md_load   = 1'b0;
        if (!test) begin
            mem_addr  = memaddress;
            mem_wdata = memwritedata;
            mem_we    = memoryoperation & memorywrite;
            md_load   = memoryoperation;
        end else begin
            case (state_q)
                S_FETCH, S_IMM: md_load = 1'b1;
                S_MEMRD: begin
                    mem_addr = (op == 4'hC) ? sp_q : a_q;
                    md_load  = 1'b1;
                end
                S_MEMWR: begin
                    mem_addr = a_q;
                    mem_we   = 1'b1;
                end
                S_PUSH: begin
                    mem_addr = sp_dec;
                    mem_we   = 1'b1;
                end
                default: ;
            endcase
        end
        if (reset) begin
            mem_we  = 1'b0;
            md_load = 1'b0;
        end
    end

    always_comb begin
        reg_widx  = rd_idx;
        reg_wdata = op[3] ? md_q : alu_res;
        reg_we    = test && (state_q == S_WB);
        if (!test) begin
            reg_widx  = registeraddress;
            reg_wdata = regwritedata;
            reg_we    = registeroperation & registerwrite;
        end
        if (reset) reg_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        if (md_load) md_q <= mem_we ? mem_wdata : mem[mem_addr[9:0]];
    end

    always_ff @(posedge clk) begin
        if (reg_we) regs[reg_widx] <= reg_wdata;
        if (!test) begin
            if (registeroperation) rd_q <= registerwrite ? regwritedata : regs[registeraddress];
        end else begin
            rd_q <= regs[rs_idx];
        end
    end

    // DECODE reads operands using the fetched word still sitting in MD, since IR loads on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= resetpc;
            sp_q    <= 16'hFFFF;
            ir_q    <= 16'h0000;
        end else if (test) begin
            case (state_q)
                S_FETCH: begin
                    pc_q    <= pc_q + 16'd1;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q <= md_q;
                    a_q  <= regs[md_q[7:4]];
                    b_q  <= regs[md_q[3:0]];
                    case (md_q[15:12])
                        4'h8, 4'hD, 4'hE, 4'hF: state_q <= S_IMM;
                        4'h9, 4'hC:             state_q <= S_MEMRD;
                        4'hA:                   state_q <= S_MEMWR;
                        4'hB:                   state_q <= S_PUSH;
                        default:                state_q <= S_EXEC;
                    endcase
                end
                S_IMM: begin
                    pc_q    <= pc_q + 16'd1;
                    state_q <= (op == 4'h8) ? S_WB : S_BRANCH;
                end
                S_EXEC: state_q <= S_WB;
                S_MEMRD: begin
                    if (op == 4'hC) sp_q <= sp_q + 16'd1;
                    state_q <= S_WB;
                end
                S_BRANCH: begin
                    if (taken) pc_q <= md_q;
                    state_q <= S_FETCH;
                end
                S_PUSH: begin
                    sp_q    <= sp_dec;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign RD    = rd_q;
    assign MD    = md_q;
    assign PC    = pc_q;
    assign SP    = sp_q;
    assign state = state_q;

`ifdef SYSTEMTEST_DEBUG_PORTS_EN
    assign FU      = (state_q == S_EXEC);
    assign RW      = (state_q == S_WB);
    assign PCW     = (state_q == S_FETCH) || (state_q == S_IMM) || ((state_q == S_BRANCH) && taken);
    assign SPW     = (state_q == S_PUSH) || ((state_q == S_MEMRD) && (op == 4'hC));
    assign MW      = (state_q == S_MEMWR) || (state_q == S_PUSH);
    assign IW      = (state_q == S_DECODE);
    assign ALUOp   = op[2:0];
    assign RWSrc   = {op == 4'hC, op == 4'h9, op == 4'h8};
    assign MSrc    = ~test;
    assign LM      = md_load;
    assign SrcB    = op[3];
    assign Jump    = (state_q == S_BRANCH) && (op == 4'hF);
    assign SPIorD  = SPW;
    assign IorD    = (state_q == S_MEMRD) || (state_q == S_MEMWR) || (state_q == S_PUSH);
    assign Perform = (state_q == S_BRANCH) && taken;
    assign LMC     = (state_q == S_MEMRD);
    assign Op      = op;
    assign x       = alu_res;
    assign y       = rd_idx;
    assign z       = (alu_res == 16'h0000);
    assign display = regs[registeraddress];
`else
    assign FU      = 1'b0;
    assign RW      = 1'b0;
    assign PCW     = 1'b0;
    assign SPW     = 1'b0;
    assign MW      = 1'b0;
    assign IW      = 1'b0;
    assign ALUOp   = 3'd0;
    assign RWSrc   = 3'd0;
    assign MSrc    = 1'b0;
    assign LM      = 1'b0;
    assign SrcB    = 1'b0;
    assign Jump    = 1'b0;
    assign SPIorD  = 1'b0;
    assign IorD    = 1'b0;
    assign Perform = 1'b0;
    assign LMC     = 1'b0;
    assign Op      = 4'd0;
    assign x       = 16'd0;
    assign y       = 4'd0;
    assign z       = 1'b0;
    assign display = 16'd0;
`endif
endmodule

// File: tb/tb_system_test.sv
// Bench for system_test: instruction-level reference model, debug-port scoreboard, random programs.
module tb_system_test;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        test = 1'b0;
    logic [15:0] resetpc = 16'h0000;
    logic        memoryoperation = 1'b0, memorywrite = 1'b0;
    logic [15:0] memaddress = 16'h0000, memwritedata = 16'h0000;
    logic        registeroperation = 1'b0, registerwrite = 1'b0;
    logic [3:0]  registeraddress = 4'h0;
    logic [15:0] regwritedata = 16'h0000;
    logic [15:0] RD, MD, PC, SP;
    logic [9:1]  state;
    logic FU, RW, PCW, SPW, MW, IW, MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC, z;
    logic [2:0]  ALUOp, RWSrc;
    logic [3:0]  Op, y;
    logic [15:0] x, display;

    system_test dut (
        .clk(clk), .reset(reset), .test(test), .resetpc(resetpc),
        .memoryoperation(memoryoperation), .memorywrite(memorywrite),
        .memaddress(memaddress), .memwritedata(memwritedata),
        .registeroperation(registeroperation), .registerwrite(registerwrite),
        .registeraddress(registeraddress), .regwritedata(regwritedata),
        .RD(RD), .MD(MD), .PC(PC), .SP(SP), .state(state),
        .FU(FU), .RW(RW), .PCW(PCW), .SPW(SPW), .MW(MW), .IW(IW), .MSrc(MSrc), .LM(LM),
        .SrcB(SrcB), .Jump(Jump), .SPIorD(SPIorD), .IorD(IorD), .Perform(Perform), .LMC(LMC), .z(z),
        .ALUOp(ALUOp), .RWSrc(RWSrc), .Op(Op), .x(x), .y(y), .display(display)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [8:0] ST_FETCH  = 9'b000000001;
    localparam logic [8:0] ST_DECODE = 9'b000000010;

    // reference model state and scoreboard queues
    logic [15:0] m_mem [1024];
    logic [15:0] m_reg [16];
    logic [15:0] m_pc, m_sp;
    logic [15:0] md_exp_q[$], rd_exp_q[$], ipc_q[$], iword_q[$], wr_addr_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // monitor: a debug access presents MD/RD one edge later
    logic md_vld = 1'b0, rd_vld = 1'b0;
    always @(posedge clk) begin
        md_vld <= !reset && !test && memoryoperation;
        rd_vld <= !reset && !test && registeroperation;
    end

    always @(negedge clk) begin
        if (md_vld) begin
            if (md_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL md_unexpected: got %h, expected no output", MD);
            end else check16("md", MD, md_exp_q.pop_front());
        end
        if (rd_vld) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %h, expected no output", RD);
            end else check16("rd", RD, rd_exp_q.pop_front());
        end
    end

    // driver tasks: called at a negedge, return at a negedge
    task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
        memoryoperation = 1'b1; memorywrite = 1'b1; memaddress = a; memwritedata = d;
        m_mem[a[9:0]] = d;
        md_exp_q.push_back(d);
        @(negedge clk);
        memoryoperation = 1'b0; memorywrite = 1'b0;
    endtask

    task automatic mem_read(input logic [15:0] a);
        memoryoperation = 1'b1; memorywrite = 1'b0; memaddress = a;
        md_exp_q.push_back(m_mem[a[9:0]]);
        @(negedge clk);
        memoryoperation = 1'b0;
    endtask

    task automatic reg_write(input logic [3:0] r, input logic [15:0] d);
        registeroperation = 1'b1; registerwrite = 1'b1; registeraddress = r; regwritedata = d;
        m_reg[r] = d;
        rd_exp_q.push_back(d);
        @(negedge clk);
        registeroperation = 1'b0; registerwrite = 1'b0;
    endtask

    task automatic reg_read_exp(input logic [3:0] r, input logic [15:0] exp);
        registeroperation = 1'b1; registerwrite = 1'b0; registeraddress = r;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        registeroperation = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] r);
        reg_read_exp(r, m_reg[r]);
    endtask

    task automatic do_reset(input logic [15:0] pc);
        reset = 1'b1; resetpc = pc;
        @(negedge clk);
        reset = 1'b0;
        m_pc = pc; m_sp = 16'hFFFF;
        check16("reset_pc", PC, pc);
        check16("reset_sp", SP, 16'hFFFF);
        check16("reset_state", {7'd0, state}, 16'h0001);
    endtask

    // instruction-level model: one call executes one whole instruction
    function automatic logic [15:0] mrd(input logic [15:0] a);
        return m_mem[a[9:0]];
    endfunction

    task automatic model_step(output int cyc);
        logic [15:0] w, a, b, imm;
        logic [3:0] op, d;
        w = mrd(m_pc);
        ipc_q.push_back(m_pc);
        iword_q.push_back(w);
        op = w[15:12]; d = w[11:8];
        a = m_reg[w[7:4]]; b = m_reg[w[3:0]];
        imm = mrd(m_pc + 16'd1);
        cyc = 4;
        m_pc = m_pc + 16'd1;
        case (op)
            4'h0: m_reg[d] = a + b;
            4'h1: m_reg[d] = a - b;
            4'h2: m_reg[d] = a & b;
            4'h3: m_reg[d] = a | b;
            4'h4: m_reg[d] = a ^ b;
            4'h5: m_reg[d] = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'h6: m_reg[d] = a << b[3:0];
            4'h7: m_reg[d] = a >> b[3:0];
            4'h8: begin m_reg[d] = imm; m_pc = m_pc + 16'd1; end
            4'h9: m_reg[d] = mrd(a);
            4'hA: begin m_mem[a[9:0]] = m_reg[d]; wr_addr_q.push_back(a); cyc = 3; end
            4'hB: begin
                m_sp = m_sp - 16'd1;
                m_mem[m_sp[9:0]] = m_reg[d];
                wr_addr_q.push_back(m_sp);
                cyc = 3;
            end
            4'hC: begin m_reg[d] = mrd(m_sp); m_sp = m_sp + 16'd1; end
            default: begin
                m_pc = m_pc + 16'd1;
                if (op == 4'hF || (op == 4'hD && m_reg[d] == a) || (op == 4'hE && m_reg[d] != a)) m_pc = imm;
            end
        endcase
    endtask

    // Runs n instructions on model then DUT; optional 10-cycle freeze at a non-FETCH cycle.
    task automatic run_instrs(input int n, input int freeze_at);
        int exp_cyc, c, cycles, fetches, budget;
        logic [15:0] ipc, hold_pc, hold_sp;
        logic [8:0] hold_st;
        bit froze;
        exp_cyc = 0;
        ipc_q.delete(); iword_q.delete();
        for (int i = 0; i < n; i++) begin
            model_step(c);
            exp_cyc += c;
        end
        budget = exp_cyc + 16; cycles = 0; fetches = 0; froze = 0;
        test = 1'b1;
        while (1) begin
            if (state == ST_FETCH) begin
                fetches++;
                if (fetches == n + 1) break;
            end
            if (state == ST_DECODE && ipc_q.size() > 0) begin
                ipc = ipc_q.pop_front();
                check16("fetch_md", MD, iword_q.pop_front());
                check16("fetch_pc", PC, ipc + 16'd1);
            end
            if (!froze && freeze_at >= 0 && cycles >= freeze_at && state != ST_FETCH) begin
                froze = 1;
                test = 1'b0;
                hold_pc = PC; hold_sp = SP; hold_st = state;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check16("freeze_pc", PC, hold_pc);
                    check16("freeze_sp", SP, hold_sp);
                    check16("freeze_state", {7'd0, state}, {7'd0, hold_st});
                end
                test = 1'b1;
            end
            if (cycles >= budget) begin
                n_checks++;
                $display("FAIL run_timeout: got %0d cycles, expected %0d", cycles, exp_cyc);
                break;
            end
            @(negedge clk);
            cycles++;
        end
        test = 1'b0;
        check16("cycles", 16'(cycles), 16'(exp_cyc));
        check16("run_pc", PC, m_pc);
        check16("run_sp", SP, m_sp);
    endtask

    function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] t;
        while (b != 0) begin
            t = a % b; a = b; b = t;
        end
        return a;
    endfunction

    task automatic euclid(input logic [15:0] a, input logic [15:0] b, input int n);
        logic [15:0] base;
        logic [15:0] prog [14];
        base = 16'h0040;
        prog = '{16'hD010, base + 16'd11, 16'h5201, 16'hE230, base + 16'd8, 16'h1001, 16'hF000,
                 base, 16'h1110, 16'hF000, base, 16'h0603, 16'hF000, base + 16'd12};
        for (int i = 0; i < 14; i++) mem_write(base + 16'(i), prog[i]);
        reg_write(4'd0, a); reg_write(4'd1, b); reg_write(4'd3, 16'h0000); reg_write(4'd6, 16'hDEAD);
        do_reset(base);
        run_instrs(n, -1);
        check16("euclid_halt_pc", PC, base + 16'd12);
        reg_read_exp(4'd6, gcd(a, b));
    endtask

    task automatic random_prog(input int freeze_at);
        logic [15:0] base;
        base = 16'h0200 + 16'($urandom_range(0, 255));
        wr_addr_q.delete();
        for (int i = 0; i < 40; i++) mem_write(base + 16'(i), 16'($urandom));
        for (int r = 0; r < 16; r++) reg_write(4'(r), 16'($urandom));
        do_reset(base);
        run_instrs(20, freeze_at);
        for (int r = 0; r < 16; r++) reg_read(4'(r));
        while (wr_addr_q.size() > 0) mem_read(wr_addr_q.pop_front());
    endtask

    // main sequence
    initial begin
        logic [15:0] ra, rb;
        @(negedge clk);
        do_reset(16'h0001);
        for (int i = 0; i < 1024; i++) mem_write(16'(i), 16'($urandom));
        for (int r = 0; r < 16; r++) reg_write(4'(r), 16'($urandom));

        mem_write(16'h0005, 16'h1234);
        mem_read(16'h0005);
        mem_read(16'h0405);
        repeat (8) mem_read(16'($urandom));

        reg_write(4'd3, 16'h00AB);
        reg_read(4'd3);
        do_reset(16'h0001);
        reg_read(4'd3);

        mem_write(16'h0001, 16'h8100);
        mem_write(16'h0002, 16'h0005);
        mem_write(16'h0003, 16'h0211);
        mem_write(16'h0004, 16'hB200);
        mem_write(16'h0005, 16'hC500);
        do_reset(16'h0001);
        run_instrs(2, -1);
        check16("prog_pc", PC, 16'h0004);
        reg_read_exp(4'd2, 16'h000A);
        reg_read(4'd1);
        run_instrs(2, -1);
        mem_read(16'hFFFE);
        reg_read_exp(4'd5, 16'h000A);

        euclid(16'd11, 16'd7, 30);
        repeat (3) begin
            ra = 16'($urandom_range(1, 12));
            rb = 16'($urandom_range(1, 12));
            euclid(ra, rb, 60);
        end

        random_prog(-1);
        random_prog($urandom_range(4, 40));
        random_prog(-1);

        repeat (3) @(negedge clk);
        check16("md_queue_drained", 16'(md_exp_q.size()), 16'd0);
        check16("rd_queue_drained", 16'(rd_exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
